// File: rtl/ram_stream_reader_if.sv
// Stream port carrying one grid cell per beat with its column/row tags.
interface ram_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [5:0]            m_col;
    logic [5:0]            m_row;
    logic                  m_eol;
    logic                  m_last;

    modport master (
        output m_valid, m_data, m_col, m_row, m_eol, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_col, m_row, m_eol, m_last,
        output m_ready
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Reads a GRID_W x GRID_H frame from a single-port RAM (1-cycle read latency)
// and streams it out with row/column tags through a 2-entry output FIFO.
module ram_stream_reader #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned GRID_W        = 50,
    parameter int unsigned GRID_H        = 50
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     mem_write_en,
    input  logic [DATA_WIDTH-1:0]    mem_data_in,
    ram_stream_reader_if.master      strm,
    output logic                     busy,
    output logic                     done
);
    localparam int unsigned TAG_W = 6;
    localparam int unsigned TOTAL = GRID_W * GRID_H;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(TOTAL - 1);
    localparam logic [TAG_W-1:0]         LAST_COL  = TAG_W'(GRID_W - 1);
    localparam logic [TAG_W-1:0]         LAST_ROW  = TAG_W'(GRID_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [TAG_W-1:0]      col;
        logic [TAG_W-1:0]      row;
        logic                  eol;
        logic                  last;
    } entry_t;

    state_t           state, state_next;
    logic [1:0]       count, count_next;
    logic             valid_q;
    logic             inflight;
    entry_t           head_q, tail_q, in_e;
    logic [TAG_W-1:0] iss_col, iss_row;
    logic [TAG_W-1:0] pend_col, pend_row;
    logic             pend_eol, pend_last;
    logic [2:0]       occ_c;
    logic             pop_c, push_c, issue_c, accept_c, last_beat_c;

    assign mem_write_en = 1'b0;

    assign strm.m_valid = valid_q;
    assign strm.m_data  = head_q.data;
    assign strm.m_col   = head_q.col;
    assign strm.m_row   = head_q.row;
    assign strm.m_eol   = head_q.eol;
    assign strm.m_last  = head_q.last;

    assign in_e = '{data: mem_data_in, col: pend_col, row: pend_row,
                    eol: pend_eol, last: pend_last};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state, read-issue credit and FIFO occupancy
    always_comb begin
        state_next  = state;
        issue_c     = 1'b0;
        accept_c    = 1'b0;
        last_beat_c = 1'b0;
        pop_c       = valid_q && strm.m_ready;
        push_c      = inflight;
        occ_c       = 3'(count) + 3'(inflight) - 3'(pop_c);
        count_next  = count;

        case (state)
            IDLE: begin
                // done high means the frame just ended; start is not yet accepted
                if (start && !done) begin
                    accept_c   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (occ_c < 3'd2) begin
                    issue_c = 1'b1;
                    if (mem_addr == LAST_ADDR) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop_c && head_q.last) begin
                    last_beat_c = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        case ({push_c, pop_c})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Address generator and tags of the read in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            iss_col   <= '0;
            iss_row   <= '0;
            inflight  <= 1'b0;
            pend_col  <= '0;
            pend_row  <= '0;
            pend_eol  <= 1'b0;
            pend_last <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            inflight <= issue_c;
            busy     <= (state_next != IDLE);
            done     <= last_beat_c;
            if (accept_c) begin
                mem_addr <= '0;
                iss_col  <= '0;
                iss_row  <= '0;
            end else if (issue_c) begin
                pend_col  <= iss_col;
                pend_row  <= iss_row;
                pend_eol  <= (iss_col == LAST_COL);
                pend_last <= (iss_col == LAST_COL) && (iss_row == LAST_ROW);
                if (mem_addr != LAST_ADDR) mem_addr <= mem_addr + ADDRESS_WIDTH'(1);
                if (iss_col == LAST_COL) begin
                    iss_col <= '0;
                    iss_row <= iss_row + TAG_W'(1);
                end else begin
                    iss_col <= iss_col + TAG_W'(1);
                end
            end
        end
    end

    // Two-entry output FIFO: head_q drives the stream, tail_q absorbs one stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count   <= count_next;
            valid_q <= (count_next != 2'd0);
            case ({push_c, pop_c})
                2'b10: begin
                    if (count == 2'd0) head_q <= in_e;
                    else               tail_q <= in_e;
                end
                2'b01: begin
                    if (count == 2'd2) head_q <= tail_q;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_q <= in_e;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= in_e;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: RAM model with mem[i]=i, expected
// beats queued per frame and compared at each handshake.
module tb_ram_stream_reader;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 12;
    localparam int unsigned GW = 50;
    localparam int unsigned GH = 50;
    localparam int unsigned N  = GW * GH;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_write_en;
    logic [DW-1:0] mem_data_in;
    logic          busy;
    logic          done;

    ram_stream_reader_if #(.DATA_WIDTH(DW)) strm ();

    ram_stream_reader #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .GRID_W(GW), .GRID_H(GH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mem_addr     (mem_addr),
        .mem_write_en (mem_write_en),
        .mem_data_in  (mem_data_in),
        .strm         (strm.master),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [5:0]    col;
        logic [5:0]    row;
        logic          eol;
        logic          last;
    } beat_t;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    beat_t         sbq [$];
    int            n_cmp   = 0;
    int            n_fail  = 0;
    bit            we_bad  = 1'b0;
    bit            addr_bad = 1'b0;

    always @(posedge clk) mem_data_in <= ram[mem_addr];

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            if (mem_write_en !== 1'b0) we_bad <= 1'b1;
            if (mem_addr > AW'(N - 1)) addr_bad <= 1'b1;
        end
    end

    function automatic beat_t observed();
        return {strm.m_data, strm.m_col, strm.m_row, strm.m_eol, strm.m_last};
    endfunction

    task automatic push_frame();
        for (int i = 0; i < int'(N); i++) begin
            beat_t b;
            b.data = DW'(i);
            b.col  = 6'(i % GW);
            b.row  = 6'(i / GW);
            b.eol  = (i % GW) == GW - 1;
            b.last = (i == N - 1);
            sbq.push_back(b);
        end
    endtask

    // mode 0: ready=1, 1: random ready, 2: ready=0 for the first 20 cycles
    task automatic run_frame(input int mode, input bit check_lat,
                             input bit inject_start, input int abort_at);
        int    beats = 0;
        int    cyc   = 0;
        bit    prev_stall = 1'b0;
        bit    first_seen = 1'b0;
        bit    finished   = 1'b0;
        beat_t prev, obs, exp_b;
        prev = '0;
        push_frame();
        strm.m_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        while (!finished && cyc < 20000) begin
            case (mode)
                0:       strm.m_ready = 1'b1;
                1:       strm.m_ready = 1'($urandom_range(0, 1));
                default: strm.m_ready = (cyc >= 20);
            endcase
            start = inject_start && (cyc == 100);
            @(negedge clk);
            obs = observed();
            if (check_lat && cyc < 3) begin
                n_cmp++;
                if (strm.m_valid !== (cyc == 2)) begin
                    n_fail++;
                    $display("FAIL latency cyc=%0d: m_valid=%b required %b", cyc, strm.m_valid, cyc == 2);
                end
            end
            if (mode == 2 && cyc == 19) begin
                n_cmp++;
                if (mem_addr > AW'(2)) begin
                    n_fail++;
                    $display("FAIL stall_reads: mem_addr=%0d required <=2", mem_addr);
                end
                n_cmp++;
                if (strm.m_valid !== 1'b1 || strm.m_data !== '0) begin
                    n_fail++;
                    $display("FAIL stall_head: valid=%b data=%h required valid=1 data=0000", strm.m_valid, strm.m_data);
                end
            end
            if (prev_stall) begin
                n_cmp++;
                if (strm.m_valid !== 1'b1 || obs !== prev) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc=%0d: valid=%b beat=%h required valid=1 beat=%h", cyc, strm.m_valid, obs, prev);
                end
            end
            if (mode == 0 && first_seen) begin
                n_cmp++;
                if (strm.m_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bubble cyc=%0d: m_valid=%b required 1", cyc, strm.m_valid);
                end
            end
            if (strm.m_valid === 1'b1) first_seen = 1'b1;
            prev_stall = (strm.m_valid === 1'b1) && !strm.m_ready;
            prev = obs;
            if (strm.m_valid === 1'b1 && strm.m_ready) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_beat: beat=%h required none", obs);
                end else begin
                    exp_b = sbq.pop_front();
                    if (obs !== exp_b) begin
                        n_fail++;
                        $display("FAIL beat%0d: got %h required %h", beats, obs, exp_b);
                    end
                end
                if (beats == 49 || beats == 50 || beats == 2499) begin
                    logic [12:0] tag_exp;
                    tag_exp = (beats == 49) ? {6'd49, 6'd0, 1'b1} :
                              (beats == 50) ? {6'd0, 6'd1, 1'b0} : {6'd49, 6'd49, 1'b1};
                    n_cmp++;
                    if ({strm.m_col, strm.m_row, strm.m_eol} !== tag_exp ||
                        strm.m_last !== (beats == 2499)) begin
                        n_fail++;
                        $display("FAIL tag%0d: col=%0d row=%0d eol=%b last=%b required %h last=%b",
                                 beats, strm.m_col, strm.m_row, strm.m_eol, strm.m_last, tag_exp, beats == 2499);
                    end
                end
                beats++;
                if (beats == int'(N)) finished = 1'b1;
                if (abort_at != 0 && beats == abort_at) break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (abort_at != 0 && beats == abort_at) return;
        if (!finished) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout: beats=%0d required %0d", beats, N);
            return;
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b busy=%b required done=1 busy=0", done, busy);
        end
        if (inject_start) start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: done=%b required 0", done);
        end
        if (inject_start) begin
            repeat (4) @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || strm.m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL start_in_done: busy=%b valid=%b required 0 0", busy, strm.m_valid);
            end
        end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d beats missing required 0", sbq.size());
        end
        n_cmp++;
        if (we_bad || addr_bad) begin
            n_fail++;
            $display("FAIL mem_port: write_en_seen=%b addr_overrange=%b required 0 0", we_bad, addr_bad);
        end
    endtask

    task automatic test_reset();
        strm.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({mem_addr, strm.m_valid, busy, done, observed()} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: addr=%h valid=%b busy=%b done=%b beat=%h required all 0",
                     mem_addr, strm.m_valid, busy, done, observed());
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (mem_addr !== '0 || strm.m_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: addr=%0d valid=%b busy=%b required 0 0 0", mem_addr, strm.m_valid, busy);
        end
    endtask

    task automatic test_full_frame();
        run_frame(0, 1'b1, 1'b0, 0);
    endtask

    task automatic test_random_ready();
        run_frame(1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_stall();
        run_frame(2, 1'b1, 1'b0, 0);
    endtask

    task automatic test_reset_mid_frame();
        run_frame(0, 1'b0, 1'b0, 1000);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_addr, strm.m_valid, busy, done, observed()} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: addr=%h valid=%b busy=%b done=%b beat=%h required all 0",
                     mem_addr, strm.m_valid, busy, done, observed());
        end
        sbq.delete();
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (mem_addr !== '0 || strm.m_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL no_stale: addr=%0d valid=%b busy=%b required 0 0 0", mem_addr, strm.m_valid, busy);
        end
        run_frame(0, 1'b1, 1'b0, 0);
    endtask

    task automatic test_start_ignored();
        run_frame(1, 1'b0, 1'b1, 0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);
        strm.m_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_random_ready();
        test_stall();
        test_reset_mid_frame();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the grid word width.
REQ-002 Parameter ADDRESS_WIDTH, default 12, SHALL set the memory address width.
REQ-003 Parameter GRID_W, default 50, SHALL set the cells per row.
REQ-004 Parameter GRID_H, default 50, SHALL set the rows per frame; GRID_W*GRID_H (2500) words are read per frame.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Port clk SHALL be an input, width 1: rising-edge clock for all state.
REQ-007 Port rst_n SHALL be an input, width 1: asynchronous active-low reset.
REQ-008 Port start SHALL be an input, width 1: request a full-frame read.
REQ-009 Port mem_addr SHALL be an output, width ADDRESS_WIDTH: address to the single-port grid RAM.
REQ-010 Port mem_write_en SHALL be an output, width 1: RAM write enable, always 0.
REQ-011 Port mem_data_in SHALL be an input, width DATA_WIDTH: RAM read data, valid one cycle after its address is presented.
REQ-012 Port m_valid SHALL be an output, width 1: stream word valid.
REQ-013 Port m_ready SHALL be an input, width 1: downstream accepts the word.
REQ-014 Port m_data SHALL be an output, width DATA_WIDTH: cell value.
REQ-015 Port m_col SHALL be an output, width 6: column index, 0..GRID_W-1.
REQ-016 Port m_row SHALL be an output, width 6: row index, 0..GRID_H-1.
REQ-017 Port m_eol SHALL be an output, width 1: high on the last cell of a row.
REQ-018 Port m_last SHALL be an output, width 1: high on cell GRID_W*GRID_H-1.
REQ-019 Port busy SHALL be an output, width 1: high from start acceptance until done.
REQ-020 Port done SHALL be an output, width 1: single-cycle frame-complete pulse.

Function
REQ-021 The FSM SHALL have states IDLE, RUN and DRAIN.
- IDLE -> RUN on start=1.
- RUN -> DRAIN after address GRID_W*GRID_H-1 is issued.
- DRAIN -> IDLE on the handshake of the m_last beat.
REQ-022 start SHALL be ignored outside IDLE.
REQ-023 Addresses SHALL be issued in ascending order 0..GRID_W*GRID_H-1, each exactly once per frame.
REQ-024 mem_addr SHALL never exceed GRID_W*GRID_H-1, and SHALL hold its last value outside RUN.
REQ-025 Read data SHALL be captured one cycle after issue into a 2-entry output FIFO; m_data, m_col, m_row, m_eol and m_last are the FIFO head.
REQ-026 A read SHALL be issued only when (FIFO occupancy + in-flight reads - pop this cycle) < 2, so no captured word is ever dropped.
REQ-027 A beat SHALL transfer when m_valid && m_ready; a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-028 While m_valid=1 and m_ready=0, m_data, m_col, m_row, m_eol and m_last SHALL be held stable, and m_valid SHALL remain 1.
REQ-029 With m_ready held at 1, throughput SHALL be one word per cycle with no bubbles after the first word.
REQ-030 Latency: start sampled at edge E0, address 0 driven after E0, and the first m_valid=1 SHALL occur after edge E2.
REQ-031 Column and row tags SHALL follow the issued address.
- Column wraps GRID_W-1 -> 0 and increments the row.
- m_eol=1 when col=GRID_W-1.
- m_last=1 only when row=GRID_H-1 and col=GRID_W-1.
REQ-032 done SHALL pulse high for exactly one cycle, in the cycle after the m_last handshake; busy SHALL fall in that same cycle.
REQ-033 A start presented in the same cycle as done SHALL be ignored; start is accepted from the next cycle.

Reset
REQ-034 rst_n=0 SHALL asynchronously force the following, regardless of state (including mid-frame):
- FSM to IDLE, FIFO empty, in-flight count 0;
- mem_addr=0, m_valid=0, busy=0, done=0;
- m_data=0, m_col=0, m_row=0, m_eol=0, m_last=0.
REQ-035 After rst_n deasserts, no read SHALL be issued until a new start is sampled; no stale word is emitted.

Verification
REQ-036 RAM preloaded with mem[i]=i, start pulse, m_ready=1 -> 2500 beats m_data=0x0000..0x09C3 on consecutive cycles; first m_valid after E2; done one cycle after beat 2499.
REQ-037 Random m_ready (50%) -> same 2500-word sequence with no loss or duplication; outputs stable during every stall.
REQ-038 m_ready=0 for 20 cycles after start -> at most 2 reads are issued; m_valid stays 1 with m_data=0x0000; on release, the stream resumes in order.
REQ-039 Tag check -> beat 49: m_col=49, m_row=0, m_eol=1; beat 50: m_col=0, m_row=1; beat 2499: m_col=49, m_row=49, m_last=1; mem_write_en=0 throughout.
REQ-040 rst_n pulsed low at beat 1000, then a new start -> all outputs at reset values immediately; the new frame restarts from address 0 and completes 2500 beats.
REQ-041 start pulsed during RUN and in the done cycle -> ignored; exactly one frame is produced.
